piezo_melody_seq: RTL and testbench

//  Parametrised tune player for the vending machine piezo. Plays one of NUM_TUNES stored

---
 rtl/piezo_melody_seq.sv | 173 +++++++++++++++++
 tb/tb_piezo_melody_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_melody_seq.sv
// Stored-melody player for the vending machine piezo: plays one of NUM_TUNES tunes
// on request, handling note timing, inter-note gaps, looping, abort and retrigger.
`timescale 1ns/1ps
module piezo_melody_seq #(
    parameter int NUM_TUNES      = 6,
    parameter int TSEL_W         = 3,
    parameter int NOTES_PER_TUNE = 4,
    parameter int NIDX_W         = 2,
    parameter int PERIOD_W       = 12,
    parameter int NOTE_LEN       = 100000,
    parameter int GAP_LEN        = 0,
    parameter int RETRIGGER      = 1,
    parameter logic [NUM_TUNES*NOTES_PER_TUNE*PERIOD_W-1:0] TUNE_ROM = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TSEL_W-1:0]   tune_sel,
    input  logic                loop,
    input  logic                stop,
    output logic                piezo,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NIDX_W-1:0]   note_idx,
    output logic [PERIOD_W-1:0] cur_period
);

    localparam int ROM_DEPTH = NUM_TUNES * NOTES_PER_TUNE;
    localparam int ADDR_W    = TSEL_W + NIDX_W;
    localparam int DUR_MAX   = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
    localparam int DUR_W     = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam int HALF_W    = PERIOD_W - 1;

    localparam logic [DUR_W-1:0]  NOTE_END  = DUR_W'(NOTE_LEN - 1);
    localparam logic [DUR_W-1:0]  GAP_END   = DUR_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [NIDX_W-1:0] LAST_NOTE = NIDX_W'(NOTES_PER_TUNE - 1);
    localparam logic [TSEL_W:0]   TUNE_LIM  = (TSEL_W + 1)'(NUM_TUNES);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t              state, state_n;
    logic [TSEL_W-1:0]   tune, tune_n;
    logic [NIDX_W-1:0]   note_n;
    logic [DUR_W-1:0]    dur_cnt, dur_n;
    logic [HALF_W-1:0]   half_cnt, half_n;
    logic                piezo_n, done_n, err_n, note_end, sel_valid;

    logic [PERIOD_W-1:0] rom [ROM_DEPTH];
    logic [ADDR_W-1:0]   rom_addr;
    logic [PERIOD_W-1:0] period;
    logic [HALF_W-1:0]   half_period;

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        assign rom[g] = TUNE_ROM[g*PERIOD_W +: PERIOD_W];
    end

    assign rom_addr    = ADDR_W'(tune) * ADDR_W'(NOTES_PER_TUNE) + ADDR_W'(note_idx);
    assign period      = rom[rom_addr];
    assign half_period = period[PERIOD_W-1:1];
    assign sel_valid   = ({1'b0, tune_sel} < TUNE_LIM);
    assign busy        = (state != IDLE);
    assign cur_period  = (state == TONE) ? period : '0;

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_n  = state;
        tune_n   = tune;
        note_n   = note_idx;
        dur_n    = dur_cnt;
        half_n   = half_cnt;
        piezo_n  = piezo;
        done_n   = 1'b0;
        err_n    = 1'b0;
        note_end = 1'b0;

        case (state)
            TONE: begin
                if (half_period == '0) begin
                    half_n  = '0;
                    piezo_n = 1'b0;
                end else if (half_cnt == half_period - HALF_W'(1)) begin
                    half_n  = '0;
                    piezo_n = ~piezo;
                end else begin
                    half_n = half_cnt + HALF_W'(1);
                end
                if (dur_cnt == NOTE_END) begin
                    dur_n = '0;
                    if (GAP_LEN > 0) begin
                        state_n = GAP;
                        half_n  = '0;
                        piezo_n = 1'b0;
                    end else begin
                        note_end = 1'b1;
                    end
                end else begin
                    dur_n = dur_cnt + DUR_W'(1);
                end
            end
            GAP: begin
                piezo_n = 1'b0;
                if (dur_cnt == GAP_END) begin
                    dur_n    = '0;
                    note_end = 1'b1;
                end else begin
                    dur_n = dur_cnt + DUR_W'(1);
                end
            end
            default: ;
        endcase

        // Each note restarts phase-aligned: counter cleared, piezo low.
        if (note_end) begin
            state_n = TONE;
            half_n  = '0;
            piezo_n = 1'b0;
            if (note_idx != LAST_NOTE) begin
                note_n = note_idx + NIDX_W'(1);
            end else begin
                note_n = '0;
                if (!loop) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        end

        // Stop outranks start even in IDLE, so a simultaneous start is dropped.
        if (stop) begin
            state_n = IDLE;
            note_n  = '0;
            dur_n   = '0;
            half_n  = '0;
            piezo_n = 1'b0;
            done_n  = 1'b0;
        end else if (start && !sel_valid) begin
            err_n = 1'b1;
        end else if (start && (state == IDLE || RETRIGGER != 0)) begin
            state_n = TONE;
            tune_n  = tune_sel;
            note_n  = '0;
            dur_n   = '0;
            half_n  = '0;
            piezo_n = 1'b0;
            done_n  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tune     <= '0;
            note_idx <= '0;
            dur_cnt  <= '0;
            half_cnt <= '0;
            piezo    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            tune     <= tune_n;
            note_idx <= note_n;
            dur_cnt  <= dur_n;
            half_cnt <= half_n;
            piezo    <= piezo_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Directed bench for piezo_melody_seq: NOTE_LEN=8, GAP_LEN=2, two instances differing
// only in RETRIGGER, checked against hand-computed cycle-by-cycle expectations.
`timescale 1ns/1ps
module tb_piezo_melody_seq;

    localparam logic [287:0] ROM = {
        12'd0,  12'd0,  12'd0,  12'd0,   // tune5 n3..n0
        12'd0,  12'd0,  12'd0,  12'd0,   // tune4
        12'd0,  12'd0,  12'd0,  12'd0,   // tune3
        12'd3,  12'd0,  12'd20, 12'd6,   // tune2
        12'd2,  12'd4,  12'd0,  12'd8,   // tune1
        12'd16, 12'd14, 12'd12, 12'd10   // tune0
    };

    logic        clk = 1'b0;
    logic        rst, start, loop, stop;
    logic [2:0]  tune_sel;
    logic        piezo1, busy1, done1, err1, piezo0, busy0, done0, err0;
    logic [1:0]  note1, note0;
    logic [11:0] per1, per0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] t1 [4] = '{12'd8, 12'd0, 12'd4, 12'd2};
    // Expected piezo for the tune1 run, index = cycle (0..40).
    logic [0:40] exp_piezo = 41'b0_0000111100_0000000000_0011001100_0101010100;

    always #5 clk = ~clk;

    piezo_melody_seq #(.NUM_TUNES(6), .TSEL_W(3), .NOTES_PER_TUNE(4), .NIDX_W(2), .PERIOD_W(12),
                       .NOTE_LEN(8), .GAP_LEN(2), .RETRIGGER(1), .TUNE_ROM(ROM)) dut (
        .clk(clk), .rst(rst), .start(start), .tune_sel(tune_sel), .loop(loop), .stop(stop),
        .piezo(piezo1), .busy(busy1), .done(done1), .err(err1), .note_idx(note1), .cur_period(per1));

    piezo_melody_seq #(.NUM_TUNES(6), .TSEL_W(3), .NOTES_PER_TUNE(4), .NIDX_W(2), .PERIOD_W(12),
                       .NOTE_LEN(8), .GAP_LEN(2), .RETRIGGER(0), .TUNE_ROM(ROM)) dut_nr (
        .clk(clk), .rst(rst), .start(start), .tune_sel(tune_sel), .loop(loop), .stop(stop),
        .piezo(piezo0), .busy(busy0), .done(done0), .err(err0), .note_idx(note0), .cur_period(per0));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic play_start(input logic [2:0] sel);
        start = 1'b1;
        tune_sel = sel;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; tune_sel = '0;
        tick(); tick();
        n_checks++; if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy1); end
        n_checks++; if (piezo1 !== 1'b0) begin n_fail++; $display("FAIL reset_piezo: got %b exp 0", piezo1); end
        n_checks++; if (done1 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b exp 0", done1); end
        n_checks++; if (err1 !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b exp 0", err1); end
        n_checks++; if (note1 !== 2'd0)  begin n_fail++; $display("FAIL reset_note: got %0d exp 0", note1); end
        n_checks++; if (per1 !== 12'd0)  begin n_fail++; $display("FAIL reset_period: got %0d exp 0", per1); end
        n_checks++; if ({busy0, piezo0} !== 2'b00) begin n_fail++; $display("FAIL reset_nr: got %b exp 00", {busy0, piezo0}); end
        rst = 1'b0;
        tick();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b exp 0", busy1); end
    endtask

    task automatic test_tune_play;
        play_start(3'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            logic [1:0]  en;
            logic [11:0] ep;
            en = 2'((cyc - 1) / 10);
            ep = (((cyc - 1) % 10) < 8) ? t1[(cyc - 1) / 10] : 12'd0;
            n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL play_busy c%0d: got %b exp 1", cyc, busy1); end
            n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL play_done c%0d: got %b exp 0", cyc, done1); end
            n_checks++; if (note1 !== en)   begin n_fail++; $display("FAIL play_note c%0d: got %0d exp %0d", cyc, note1, en); end
            n_checks++; if (per1 !== ep)    begin n_fail++; $display("FAIL play_period c%0d: got %0d exp %0d", cyc, per1, ep); end
            n_checks++; if (piezo1 !== exp_piezo[cyc]) begin
                n_fail++; $display("FAIL play_piezo c%0d: got %b exp %b", cyc, piezo1, exp_piezo[cyc]);
            end
            tick();
        end
        n_checks++; if ({busy1, done1} !== 2'b01) begin n_fail++; $display("FAIL play_end c41 busy,done: got %b exp 01", {busy1, done1}); end
        n_checks++; if ({note1, per1} !== 14'd0)  begin n_fail++; $display("FAIL play_end_idle c41: got %0d/%0d exp 0/0", note1, per1); end
        tick();
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL play_done_pulse c42: got %b exp 0", done1); end
    endtask

    task automatic test_loop;
        loop = 1'b1;
        play_start(3'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            n_checks++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL loop_pass1 c%0d busy,done: got %b exp 10", cyc, {busy1, done1}); end
            tick();
        end
        n_checks++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL loop_wrap c41 busy,done: got %b exp 10", {busy1, done1}); end
        n_checks++; if (note1 !== 2'd0)  begin n_fail++; $display("FAIL loop_wrap_note c41: got %0d exp 0", note1); end
        n_checks++; if (per1 !== 12'd8)  begin n_fail++; $display("FAIL loop_wrap_period c41: got %0d exp 8", per1); end
        loop = 1'b0;
        for (int cyc = 41; cyc <= 80; cyc++) begin
            n_checks++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL loop_pass2 c%0d busy,done: got %b exp 10", cyc, {busy1, done1}); end
            tick();
        end
        n_checks++; if ({busy1, done1} !== 2'b01) begin n_fail++; $display("FAIL loop_end c81 busy,done: got %b exp 01", {busy1, done1}); end
        tick();
    endtask

    task automatic test_stop;
        play_start(3'd1);
        for (int cyc = 1; cyc < 15; cyc++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL stop_busy c16: got %b exp 0", busy1); end
        n_checks++; if (piezo1 !== 1'b0) begin n_fail++; $display("FAIL stop_piezo c16: got %b exp 0", piezo1); end
        n_checks++; if (note1 !== 2'd0)  begin n_fail++; $display("FAIL stop_note c16: got %0d exp 0", note1); end
        n_checks++; if (per1 !== 12'd0)  begin n_fail++; $display("FAIL stop_period c16: got %0d exp 0", per1); end
        for (int cyc = 16; cyc < 46; cyc++) begin
            n_checks++; if ({busy1, done1} !== 2'b00) begin n_fail++; $display("FAIL stop_quiet c%0d busy,done: got %b exp 00", cyc, {busy1, done1}); end
            tick();
        end
        start = 1'b1; stop = 1'b1; tune_sel = 3'd1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_checks++; if ({busy1, err1} !== 2'b00) begin n_fail++; $display("FAIL start_stop busy,err: got %b exp 00", {busy1, err1}); end
        tick();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL start_stop_after: got %b exp 0", busy1); end
    endtask

    task automatic test_retrigger;
        play_start(3'd1);
        for (int cyc = 1; cyc < 25; cyc++) tick();
        start = 1'b1; tune_sel = 3'd2;
        tick();
        start = 1'b0;
        n_checks++; if (note1 !== 2'd0)  begin n_fail++; $display("FAIL retrig_note c26: got %0d exp 0", note1); end
        n_checks++; if (per1 !== 12'd6)  begin n_fail++; $display("FAIL retrig_period c26: got %0d exp 6", per1); end
        n_checks++; if (piezo1 !== 1'b0) begin n_fail++; $display("FAIL retrig_piezo c26: got %b exp 0", piezo1); end
        n_checks++; if (note0 !== 2'd2)  begin n_fail++; $display("FAIL noretrig_note c26: got %0d exp 2", note0); end
        n_checks++; if (per0 !== 12'd4)  begin n_fail++; $display("FAIL noretrig_period c26: got %0d exp 4", per0); end
        for (int cyc = 26; cyc <= 70; cyc++) begin
            logic [1:0] e1, e0;
            e1 = {cyc < 66, cyc == 66};
            e0 = {cyc < 41, cyc == 41};
            n_checks++; if ({busy1, done1} !== e1) begin n_fail++; $display("FAIL retrig_run c%0d busy,done: got %b exp %b", cyc, {busy1, done1}, e1); end
            n_checks++; if ({busy0, done0} !== e0) begin n_fail++; $display("FAIL noretrig_run c%0d busy,done: got %b exp %b", cyc, {busy0, done0}, e0); end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        play_start(3'd1);
        for (int cyc = 1; cyc < 41; cyc++) tick();
        n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL b2b_done c41: got %b exp 1", done1); end
        start = 1'b1; tune_sel = 3'd0;
        tick();
        start = 1'b0;
        n_checks++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL b2b_restart busy,done: got %b exp 10", {busy1, done1}); end
        n_checks++; if (note1 !== 2'd0)  begin n_fail++; $display("FAIL b2b_note: got %0d exp 0", note1); end
        n_checks++; if (per1 !== 12'd10) begin n_fail++; $display("FAIL b2b_period: got %0d exp 10", per1); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got %b exp 0", busy1); end
        tick();
    endtask

    task automatic test_err_and_reset;
        start = 1'b1; tune_sel = 3'd7;
        tick();
        start = 1'b0;
        n_checks++; if ({err1, busy1} !== 2'b10) begin n_fail++; $display("FAIL err7 err,busy: got %b exp 10", {err1, busy1}); end
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL err7_nr: got %b exp 1", err0); end
        tick();
        n_checks++; if ({err1, busy1} !== 2'b00) begin n_fail++; $display("FAIL err7_pulse err,busy: got %b exp 00", {err1, busy1}); end
        start = 1'b1; tune_sel = 3'd6;
        tick();
        start = 1'b0;
        n_checks++; if ({err1, busy1} !== 2'b10) begin n_fail++; $display("FAIL err6 err,busy: got %b exp 10", {err1, busy1}); end
        start = 1'b1; tune_sel = 3'd5;
        tick();
        start = 1'b0;
        n_checks++; if ({err1, busy1} !== 2'b01) begin n_fail++; $display("FAIL sel5 err,busy: got %b exp 01", {err1, busy1}); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        play_start(3'd0);
        for (int cyc = 1; cyc < 17; cyc++) tick();
        n_checks++; if ({note1, piezo1} !== 3'b011) begin n_fail++; $display("FAIL pre_rst c17 note,piezo: got %b exp 011", {note1, piezo1}); end
        n_checks++; if (per1 !== 12'd12) begin n_fail++; $display("FAIL pre_rst_period c17: got %0d exp 12", per1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({busy1, piezo1, done1, err1} !== 4'b0000) begin
            n_fail++; $display("FAIL midtone_rst flags: got %b exp 0000", {busy1, piezo1, done1, err1});
        end
        n_checks++; if ({note1, per1} !== 14'd0) begin n_fail++; $display("FAIL midtone_rst note/period: got %0d/%0d exp 0/0", note1, per1); end
        tick();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL midtone_rst_after: got %b exp 0", busy1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tune_play();
        test_loop();
        test_stop();
        test_retrigger();
        test_back_to_back();
        test_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
